// File: rtl/mem_arb_pkg.sv
// Shared widths, state encoding and request payload for the memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap-around.
module rr_pick #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int unsigned k;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      k     = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         k = (32'(ptr) + i) % NUM_REQ;
         if (!any && req[k]) begin
            any      = 1'b1;
            grant[k] = 1'b1;
            idx      = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters,
// with a watchdog that turns a missing memory response into an error response.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        arb_req_valid,
   output logic [NUM_REQ-1:0]        arb_req_ready,
   input  logic [NUM_REQ-1:0]        arb_req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] arb_req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] arb_req_wdata,
   output logic [NUM_REQ-1:0]        arb_rsp_valid,
   output logic                      arb_rsp_err,
   output logic [DATA_W-1:0]         arb_rsp_rdata,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic                      mem_valid,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      busy,
   output logic                      timeout_flag
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     gnt_q, gnt_d;
   logic [IDX_W-1:0]     rr_q, rr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   mem_req_t             req_q, req_d;
   logic                 mem_req_q, mem_req_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic                 busy_q, busy_d;
   logic                 tflag_q, tflag_d;

   logic [NUM_REQ-1:0]   pick_grant;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req   (arb_req_valid),
      .ptr   (rr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Grant is only offered while idle; the picker only selects valid requesters.
   assign arb_req_ready = (state_q == IDLE) ? pick_grant : '0;

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      rr_d        = rr_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      mem_req_d   = 1'b0;
      rsp_valid_d = '0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      tflag_d     = tflag_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d       = pick_idx;
               rr_d        = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
               req_d.we    = arb_req_we[pick_idx];
               req_d.addr  = arb_req_addr[ADDR_W*pick_idx +: ADDR_W];
               req_d.wdata = arb_req_wdata[DATA_W*pick_idx +: DATA_W];
               mem_req_d   = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A completion in the timeout cycle still counts as a success.
            if (mem_valid) begin
               rsp_valid_d = NUM_REQ'(1) << gnt_q;
               rsp_rdata_d = req_q.we ? '0 : mem_rdata;
               state_d     = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
               rsp_valid_d = NUM_REQ'(1) << gnt_q;
               rsp_err_d   = 1'b1;
               tflag_d     = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         rr_q        <= '0;
         cnt_q       <= '0;
         req_q       <= '0;
         mem_req_q   <= 1'b0;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         busy_q      <= 1'b0;
         tflag_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         rr_q        <= rr_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         mem_req_q   <= mem_req_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         busy_q      <= busy_d;
         tflag_q     <= tflag_d;
      end
   end

   assign mem_req       = mem_req_q;
   assign mem_we        = req_q.we;
   assign mem_addr      = req_q.addr;
   assign mem_wdata     = req_q.wdata;
   assign arb_rsp_valid = rsp_valid_q;
   assign arb_rsp_err   = rsp_err_q;
   assign arb_rsp_rdata = rsp_rdata_q;
   assign busy          = busy_q;
   assign timeout_flag  = tflag_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a latency-programmable memory model.
module tb_mem_port_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] arb_req_valid;
   logic [NR-1:0] arb_req_ready;
   logic [NR-1:0] arb_req_we;
   logic [NR*64-1:0] arb_req_addr;
   logic [NR*64-1:0] arb_req_wdata;
   logic [NR-1:0] arb_rsp_valid;
   logic          arb_rsp_err;
   logic [63:0]   arb_rsp_rdata;
   logic          mem_req, mem_we;
   logic [63:0]   mem_addr, mem_wdata;
   logic          mem_valid;
   logic [63:0]   mem_rdata;
   logic          busy, timeout_flag;

   int            n_checks = 0;
   int            n_fail   = 0;

   // Memory model: mem_valid high mem_lat cycles after the mem_req cycle; 0 means never.
   int            mem_lat  = 1;
   logic [63:0]   mem_data = '0;
   int            pend;

   mem_port_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .arb_req_valid(arb_req_valid), .arb_req_ready(arb_req_ready),
      .arb_req_we(arb_req_we), .arb_req_addr(arb_req_addr), .arb_req_wdata(arb_req_wdata),
      .arb_rsp_valid(arb_rsp_valid), .arb_rsp_err(arb_rsp_err), .arb_rsp_rdata(arb_rsp_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_valid(mem_valid), .mem_rdata(mem_rdata),
      .busy(busy), .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend      <= 0;
         mem_valid <= 1'b0;
         mem_rdata <= '0;
      end else begin
         mem_valid <= 1'b0;
         if (mem_req && mem_lat > 0) begin
            if (mem_lat == 1) begin
               mem_valid <= 1'b1;
               mem_rdata <= mem_data;
            end else begin
               pend <= mem_lat - 1;
            end
         end else if (pend == 1) begin
            mem_valid <= 1'b1;
            mem_rdata <= mem_data;
            pend      <= 0;
         end else if (pend > 1) begin
            pend <= pend - 1;
         end
      end
   end

   // Presents one request during an idle cycle, samples ready, and returns one cycle later.
   task automatic accept(input int r, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, output logic [NR-1:0] rdy);
      arb_req_valid              = '0;
      arb_req_valid[r]           = 1'b1;
      arb_req_we                 = '0;
      arb_req_we[r]              = we;
      arb_req_addr[r*64 +: 64]   = addr;
      arb_req_wdata[r*64 +: 64]  = wdata;
      #1 rdy = arb_req_ready;
      @(negedge clk);
      arb_req_valid = '0;
   endtask

   task automatic wait_rsp(input int max, output int cyc, output logic got);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < max) begin
         @(negedge clk);
         cyc++;
         if (arb_rsp_valid != '0) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      arb_req_valid = '0; arb_req_we = '0; arb_req_addr = '0; arb_req_wdata = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if (arb_rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0000", arb_rsp_valid); end
      n_checks++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL reset_tflag got=%b exp=0", timeout_flag); end
      n_checks++; if (mem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      n_checks++; if (arb_req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", arb_req_ready); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fairness();
      logic [NR-1:0] prev, exp;
      int k, cyc, last;
      mem_lat = 1; mem_data = 64'h77;
      prev = '0; k = 0; cyc = 0; last = 0;
      arb_req_valid = 4'b1111;
      while (k < 8 && cyc < 100) begin
         #1;
         if (arb_req_ready != '0) begin
            exp = 4'b0001 << (k % 4);
            n_checks++; if (arb_req_ready !== exp) begin n_fail++; $display("FAIL fair_grant%0d got=%b exp=%b", k, arb_req_ready, exp); end
            n_checks++; if (arb_req_ready === prev) begin n_fail++; $display("FAIL fair_repeat%0d got=%b prev=%b", k, arb_req_ready, prev); end
            if (k > 0) begin
               n_checks++; if (cyc - last !== 4) begin n_fail++; $display("FAIL fair_gap%0d got=%0d exp=4", k, cyc - last); end
            end
            prev = arb_req_ready; last = cyc; k++;
         end
         @(negedge clk);
         cyc++;
      end
      arb_req_valid = '0;
      n_checks++; if (k !== 8) begin n_fail++; $display("FAIL fair_count got=%0d exp=8", k); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_read();
      logic [NR-1:0] rdy;
      mem_lat = 1; mem_data = 64'hDEADBEEF;
      accept(1, 1'b0, 64'h100, 64'h0, rdy);
      n_checks++; if (rdy !== 4'b0010) begin n_fail++; $display("FAIL rd_ready got=%b exp=0010", rdy); end
      n_checks++; if ({mem_req, mem_we} !== 2'b10) begin n_fail++; $display("FAIL rd_mem_req_we got=%b exp=10", {mem_req, mem_we}); end
      n_checks++; if (mem_addr !== 64'h100) begin n_fail++; $display("FAIL rd_mem_addr got=%h exp=100", mem_addr); end
      n_checks++; if ({busy, arb_req_ready} !== 5'b10000) begin n_fail++; $display("FAIL rd_busy_ready got=%b exp=10000", {busy, arb_req_ready}); end
      @(negedge clk);
      n_checks++; if ({mem_req, arb_rsp_valid} !== 5'b00000) begin n_fail++; $display("FAIL rd_single_pulse got=%b exp=00000", {mem_req, arb_rsp_valid}); end
      @(negedge clk);
      n_checks++; if (arb_rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL rd_rsp_valid got=%b exp=0010", arb_rsp_valid); end
      n_checks++; if (arb_rsp_rdata !== 64'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata got=%h exp=deadbeef", arb_rsp_rdata); end
      n_checks++; if (arb_rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_err got=%b exp=0", arb_rsp_err); end
      @(negedge clk);
      n_checks++; if ({busy, arb_rsp_valid} !== 5'b00000) begin n_fail++; $display("FAIL rd_done got=%b exp=00000", {busy, arb_rsp_valid}); end
   endtask

   task automatic test_write();
      logic [NR-1:0] rdy;
      int cyc; logic got;
      mem_lat = 1; mem_data = 64'hFFFF_0000_FFFF;
      accept(3, 1'b1, 64'h20, 64'h55, rdy);
      n_checks++; if (rdy !== 4'b1000) begin n_fail++; $display("FAIL wr_ready got=%b exp=1000", rdy); end
      n_checks++; if ({mem_req, mem_we} !== 2'b11) begin n_fail++; $display("FAIL wr_mem_req_we got=%b exp=11", {mem_req, mem_we}); end
      n_checks++; if ({mem_addr, mem_wdata} !== {64'h20, 64'h55}) begin n_fail++; $display("FAIL wr_addr_data got=%h/%h exp=20/55", mem_addr, mem_wdata); end
      wait_rsp(10, cyc, got);
      n_checks++; if ({got, cyc[3:0]} !== 5'b10010) begin n_fail++; $display("FAIL wr_rsp_latency got=%b/%0d exp=1/2", got, cyc); end
      n_checks++; if ({arb_rsp_valid, arb_rsp_err, arb_rsp_rdata} !== {4'b1000, 1'b0, 64'h0}) begin
         n_fail++; $display("FAIL wr_rsp got=%b/%b/%h exp=1000/0/0", arb_rsp_valid, arb_rsp_err, arb_rsp_rdata); end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      logic [NR-1:0] rdy;
      int cyc; logic got;
      mem_lat = 0; mem_data = 64'hBAD;
      accept(0, 1'b0, 64'h40, 64'h0, rdy);
      n_checks++; if ({rdy, mem_req} !== 5'b00011) begin n_fail++; $display("FAIL to_accept got=%b exp=00011", {rdy, mem_req}); end
      wait_rsp(40, cyc, got);
      n_checks++; if (got !== 1'b1 || cyc !== TO + 2) begin n_fail++; $display("FAIL to_latency got=%b/%0d exp=1/%0d", got, cyc, TO + 2); end
      n_checks++; if ({arb_rsp_valid, arb_rsp_err, arb_rsp_rdata} !== {4'b0001, 1'b1, 64'h0}) begin
         n_fail++; $display("FAIL to_rsp got=%b/%b/%h exp=0001/1/0", arb_rsp_valid, arb_rsp_err, arb_rsp_rdata); end
      n_checks++; if (timeout_flag !== 1'b1) begin n_fail++; $display("FAIL to_flag got=%b exp=1", timeout_flag); end
      @(negedge clk);
      mem_lat = 1; mem_data = 64'h1234;
      accept(1, 1'b0, 64'h48, 64'h0, rdy);
      wait_rsp(10, cyc, got);
      n_checks++; if (got !== 1'b1 || cyc !== 2) begin n_fail++; $display("FAIL to_next_latency got=%b/%0d exp=1/2", got, cyc); end
      n_checks++; if ({arb_rsp_valid, arb_rsp_err, arb_rsp_rdata} !== {4'b0010, 1'b0, 64'h1234}) begin
         n_fail++; $display("FAIL to_next_rsp got=%b/%b/%h exp=0010/0/1234", arb_rsp_valid, arb_rsp_err, arb_rsp_rdata); end
      n_checks++; if (timeout_flag !== 1'b1) begin n_fail++; $display("FAIL to_flag_sticky got=%b exp=1", timeout_flag); end
      @(negedge clk);
   endtask

   task automatic test_late_and_tie();
      logic [NR-1:0] rdy, seen;
      int cyc; logic got;
      mem_lat = TO + 1; mem_data = 64'hCAFE;
      accept(2, 1'b0, 64'h80, 64'h0, rdy);
      wait_rsp(40, cyc, got);
      n_checks++; if (got !== 1'b1 || cyc !== TO + 2) begin n_fail++; $display("FAIL tie_latency got=%b/%0d exp=1/%0d", got, cyc, TO + 2); end
      n_checks++; if ({arb_rsp_valid, arb_rsp_err, arb_rsp_rdata} !== {4'b0100, 1'b0, 64'hCAFE}) begin
         n_fail++; $display("FAIL tie_rsp got=%b/%b/%h exp=0100/0/cafe", arb_rsp_valid, arb_rsp_err, arb_rsp_rdata); end
      @(negedge clk);
      mem_lat = TO + 2; mem_data = 64'hBEEF;
      accept(2, 1'b0, 64'h88, 64'h0, rdy);
      wait_rsp(40, cyc, got);
      n_checks++; if (got !== 1'b1 || cyc !== TO + 2) begin n_fail++; $display("FAIL late_latency got=%b/%0d exp=1/%0d", got, cyc, TO + 2); end
      n_checks++; if ({arb_rsp_valid, arb_rsp_err, arb_rsp_rdata} !== {4'b0100, 1'b1, 64'h0}) begin
         n_fail++; $display("FAIL late_rsp got=%b/%b/%h exp=0100/1/0", arb_rsp_valid, arb_rsp_err, arb_rsp_rdata); end
      seen = '0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | arb_rsp_valid;
      end
      n_checks++; if ({seen, busy} !== 5'b00000) begin n_fail++; $display("FAIL late_extra got=%b exp=00000", {seen, busy}); end
   endtask

   task automatic test_reset_mid();
      logic [NR-1:0] rdy, seen;
      mem_lat = 0;
      accept(2, 1'b1, 64'h300, 64'hA5, rdy);
      repeat (3) @(negedge clk);
      n_checks++; if ({busy, mem_we} !== 2'b11) begin n_fail++; $display("FAIL rst_pre got=%b exp=11", {busy, mem_we}); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if ({mem_req, mem_we, busy, timeout_flag} !== 4'b0000) begin
         n_fail++; $display("FAIL rst_async_ctrl got=%b exp=0000", {mem_req, mem_we, busy, timeout_flag}); end
      n_checks++; if ({mem_addr, mem_wdata} !== 128'h0) begin n_fail++; $display("FAIL rst_async_data got=%h/%h exp=0/0", mem_addr, mem_wdata); end
      n_checks++; if ({arb_rsp_valid, arb_rsp_err, arb_rsp_rdata} !== 69'h0) begin
         n_fail++; $display("FAIL rst_async_rsp got=%b/%b/%h exp=0/0/0", arb_rsp_valid, arb_rsp_err, arb_rsp_rdata); end
      @(negedge clk);
      rst_n = 1'b1;
      mem_lat = 1;
      seen = '0;
      repeat (25) begin
         @(negedge clk);
         seen = seen | arb_rsp_valid;
      end
      n_checks++; if ({seen, busy} !== 5'b00000) begin n_fail++; $display("FAIL rst_no_rsp got=%b exp=00000", {seen, busy}); end
      arb_req_valid = 4'b1111;
      #1;
      n_checks++; if (arb_req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_first_grant got=%b exp=0001", arb_req_ready); end
      @(negedge clk);
      arb_req_valid = '0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_single_read();
      test_write();
      test_timeout();
      test_late_and_tie();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
